prbs_led_status: RTL
====================

// Module: prbs_led_status
// PURPOSE
//  Consumes the PRBS test FSM's outputs and rx checker flags; drives board LEDs (heartbeat, test state, fault, error activity).
//  Keeps a saturating count of unexpected post-verification bit errors.
//  Sits directly downstream of the PRBS test FSM, beside the rx PRBS checker.
// PARAMETERS
//  TICK_DIV       20_000_000  clk cycles per blink tick (>=2)
//  STRETCH_TICKS  2           ticks led[3] stays lit after last rx_prbs_err (>=1)
//  ERR_CNT_W      16          err_count width
// PORTS
//  clk            in   1          single clock, all logic on posedge
//  reset_n        in   1          asynchronous, active-low reset
//  pll_lock       in   1          high = PLL relocking; synchronous clear to reset state
//  rx_prbs_mode   in   3          non-zero = checker running
//  prbs_test_pass in   1          sticky: injected error was detected
//  rx_prbs_err    in   1          checker error flag, per cycle
//  error_inject   in   1          high = errors are deliberately injected
//  clear_fault    in   1          one-cycle pulse; clears FAULT and err_count
//  led            out  4          [0] heartbeat [1] state [2] fault [3] err activity
//  err_count      out  ERR_CNT_W  unexpected error cycles, saturating
//  fault          out  1          high while state==FAULT
// BEHAVIOUR
//  Reset (reset_n low, or pll_lock high at a clk edge):
//   - state=IDLE; prescaler, phase, stretch count and err_count =0; led=4'b0000; fault=0.
//  Tick: prescaler counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when prescaler==TICK_DIV-1. phase toggles on tick.
//  FSM (registered):
//   - Any state -> IDLE when rx_prbs_mode==0. Highest priority.
//   - IDLE -> ARMED when rx_prbs_mode!=0.
//   - ARMED -> VERIFIED when prbs_test_pass. Errors in ARMED are expected and ignored.
//   - VERIFIED -> FAULT when rx_prbs_err && !error_inject.
//   - FAULT -> VERIFIED on clear_fault. Otherwise FAULT is sticky.
//  LEDs (registered; 1 cycle after state/phase change):
//   - led[0] = phase in all states.
//   - led[1]: IDLE 0; ARMED = phase; VERIFIED 1; FAULT 0.
//   - led[2] = (state==FAULT). fault = same value, unregistered from state.
//  Stretcher:
//   - Any rx_prbs_err cycle (any state except IDLE) loads stretch count with STRETCH_TICKS.
//   - Else stretch count decrements on tick while !=0.
//   - led[3] = (count!=0). Load beats decrement in the same cycle.
//  err_count:
//   - +1 per cycle with rx_prbs_err && !error_inject && state in {VERIFIED,FAULT}.
//   - Saturates at all-ones; no wrap.
//   - Cleared on entry to ARMED and on clear_fault. Clear wins over a same-cycle increment.
//  clear_fault outside FAULT: clears err_count only.
//  Reset mid-blink: prescaler restarts from 0 and phase returns to 0.
// CONFIGURATION
//  PRBS_LED_ERRCNT_EN defined: err_count logic is built as above.
//  Not defined: err_count tied to 0 and no counter is synthesized. FSM, fault and LEDs are unchanged.
// STRUCTURE
//  Shared package prbs_led_pkg holds:
//   - state encoding: IDLE=2'd0, ARMED=2'd1, VERIFIED=2'd2, FAULT=2'd3;
//   - LED index constants LED_HB=0, LED_STATE=1, LED_FAULT=2, LED_ERR=3.
//  Sub-module led_tick_gen (#(TICK_DIV); clk, reset_n, clr -> tick) holds the prescaler. Everything else is top-level.
// TESTING (TICK_DIV=4, STRETCH_TICKS=2, ERR_CNT_W=4)
//  1. Release reset_n; mode=0 for 16 cycles:
//     -> tick every 4th cycle; led[0] toggles every 4 cycles; led[3:1]=0; err_count=0.
//  2. mode=3'b001, then prbs_test_pass=1 at cycle 10:
//     -> ARMED, led[1] blinks with phase; VERIFIED at cycle 11; led[1]=1 at cycle 12.
//  3. In ARMED, error_inject=1 and rx_prbs_err=1 for 5 cycles:
//     -> no FAULT; err_count=0; led[3]=1 until 2 ticks after the last error.
//  4. In VERIFIED, rx_prbs_err=1 and error_inject=0 for 20 cycles:
//     -> FAULT next cycle; fault=1; led[2]=1; err_count saturates at 4'hF.
//  5. clear_fault pulse together with rx_prbs_err=1 while in FAULT:
//     -> err_count=0; state back to VERIFIED; led[2]=0 two cycles later.
//  6. pll_lock=1 for 1 cycle in FAULT, then mode=0 while in VERIFIED:
//     -> immediate IDLE; all counters and LEDs 0. Repeat with macro undefined -> err_count stays 0.

Source files
------------

// File: rtl/prbs_led_pkg.sv
// Shared definitions for the PRBS LED status block: FSM state encoding,
// LED bit positions and the LED pattern decode used by the top level.
package prbs_led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    VERIFIED = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam int LED_HB    = 0;
  localparam int LED_STATE = 1;
  localparam int LED_FAULT = 2;
  localparam int LED_ERR   = 3;

  // LED image for a given test state, blink phase and error-activity flag.
  function automatic logic [3:0] led_pattern(input state_t st, input logic phase,
                                             input logic err_act);
    logic [3:0] l;
    l = '0;
    l[LED_HB] = phase;
    case (st)
      ARMED:    l[LED_STATE] = phase;
      VERIFIED: l[LED_STATE] = 1'b1;
      default:  l[LED_STATE] = 1'b0;
    endcase
    l[LED_FAULT] = (st == FAULT);
    l[LED_ERR]   = err_act;
    return l;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink prescaler: counts 0..TICK_DIV-1 and wraps, flagging the last count
// as a one-cycle tick. clr restarts the count from zero.
module led_tick_gen #(
  parameter int TICK_DIV = 20_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] prescaler;

  // Free-running prescaler with wrap and synchronous clear.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see the updated count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if (clr || prescaler == LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

  assign tick = (prescaler == LAST);

endmodule

// File: rtl/prbs_led_status.sv
// PRBS test status indicator: tracks the test FSM (IDLE/ARMED/VERIFIED/FAULT),
// drives heartbeat, state, fault and stretched error-activity LEDs, and
// counts unexpected post-verification error cycles.
// Build option: define PRBS_LED_ERRCNT_EN to build the saturating err_count;
// otherwise err_count is tied to zero.
module prbs_led_status
  import prbs_led_pkg::*;
#(
  parameter int TICK_DIV      = 20_000_000,
  parameter int STRETCH_TICKS = 2,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pll_lock,
  input  logic [2:0]           rx_prbs_mode,
  input  logic                 prbs_test_pass,
  input  logic                 rx_prbs_err,
  input  logic                 error_inject,
  input  logic                 clear_fault,
  output logic [3:0]           led,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 fault
);

  localparam int               STR_W        = $clog2(STRETCH_TICKS + 1);
  localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_TICKS);

  state_t           state;
  logic             phase;
  logic             tick;
  logic [STR_W-1:0] stretch;
  logic             mode_on;

  assign mode_on = (rx_prbs_mode != 3'd0);
  assign fault   = (state == FAULT);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pll_lock),
    .tick    (tick)
  );

  // Test FSM, blink phase and registered LED image (LEDs lag state by a cycle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= 1'b0;
      led   <= '0;
    end else if (pll_lock) begin
      state <= IDLE;
      phase <= 1'b0;
      led   <= '0;
    end else begin
      if (tick) phase <= ~phase;
      led <= led_pattern(state, phase, stretch != '0);
      if (!mode_on) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:     state <= ARMED;
          ARMED:    if (prbs_test_pass) state <= VERIFIED;
          VERIFIED: if (rx_prbs_err && !error_inject) state <= FAULT;
          FAULT:    if (clear_fault) state <= VERIFIED;
        endcase
      end
    end
  end

  // Error-activity stretcher: reload on any error outside IDLE, drain on ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stretch <= '0;
    end else if (pll_lock) begin
      stretch <= '0;
    end else if (rx_prbs_err && state != IDLE) begin
      stretch <= STRETCH_LOAD;
    end else if (tick && stretch != '0) begin
      stretch <= stretch - STR_W'(1);
    end
  end

`ifdef PRBS_LED_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 cnt_clr;
  logic                 cnt_inc;

  // Clearing on entry to ARMED and on clear_fault takes precedence over counting.
  assign cnt_clr = clear_fault || (state == IDLE && mode_on);
  assign cnt_inc = rx_prbs_err && !error_inject && (state == VERIFIED || state == FAULT);

  // Saturating count of unexpected error cycles after verification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (pll_lock || cnt_clr) begin
      err_cnt_q <= '0;
    end else if (cnt_inc && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
